// File: rtl/mips_fetch_unit_if.sv
// mips_fetch_unit_if: imem request/response, redirect and instruction delivery signals of the fetch stage
interface mips_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        misalign_err;
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, misalign_err,
    input  imem_ack, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, misalign_err,
    output imem_ack, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: prefetching fetch stage with redirect flush; define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects
module mips_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic               clk,
  input logic               reset,
  mips_fetch_unit_if.master bus
);
  localparam int AW = $clog2(DEPTH);
`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {FETCH, DRAIN, HALT} state_t;
  logic misalign_q, mis;
`else
  typedef enum logic {FETCH, DRAIN} state_t;
`endif
  state_t        state_q, idle_st;
  logic          run_q, push, pop, redirect;
  logic [AW:0]   count_q;
  logic [AW-1:0] rd_q, wr_q;
  logic [31:0]   fetch_pc_q, drain_pc_q, target;
  logic [31:0]   ins_q [DEPTH];
  logic [31:0]   pc_q [DEPTH];
  // run_q delays the first request to the cycle after reset is released
  always_comb begin
    redirect = bus.redirect_valid;
    target = bus.redirect_pc & 32'hFFFF_FFFC;
    bus.imem_req = run_q && (state_q == DRAIN || (state_q == FETCH && count_q < (AW+1)'(DEPTH)));
    bus.imem_addr = state_q == DRAIN ? drain_pc_q : fetch_pc_q;
    bus.instr_valid = count_q != '0;
    bus.instr = bus.instr_valid ? ins_q[rd_q] : '0;
    bus.instr_pc = bus.instr_valid ? pc_q[rd_q] : '0;
    push = !redirect && state_q == FETCH && bus.imem_req && bus.imem_ack;
    pop = !redirect && bus.instr_valid && bus.instr_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
    mis = bus.redirect_pc[1:0] != 2'b00;
    idle_st = (redirect ? mis : misalign_q) ? HALT : FETCH;
    bus.misalign_err = misalign_q;
`else
    idle_st = FETCH;
    bus.misalign_err = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      run_q <= 1'b0;
      count_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      fetch_pc_q <= RESET_PC;
      drain_pc_q <= RESET_PC;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      run_q <= 1'b1;
      if (push) begin
        ins_q[wr_q] <= bus.imem_rdata;
        pc_q[wr_q] <= fetch_pc_q;
        wr_q <= wr_q + AW'(1);
        fetch_pc_q <= fetch_pc_q + 32'd4;
      end
      if (pop) rd_q <= rd_q + AW'(1);
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
      // an unacked request must complete at its old address before the target is fetched
      if (redirect) begin
        count_q <= '0;
        rd_q <= wr_q;
        fetch_pc_q <= target;
        drain_pc_q <= bus.imem_addr;
        state_q <= bus.imem_req && !bus.imem_ack ? DRAIN : idle_st;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_q <= mis;
`endif
      end else if (state_q == DRAIN && bus.imem_ack) state_q <= idle_st;
    end
  end
endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: directed scenarios plus randomized run against a queue-based reference model
module tb_mips_fetch_unit;
  localparam int DEPTH = 4;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  bit rand_data = 1'b0;
  logic [63:0] m_q[$];
  logic [31:0] m_pc = 32'h0, m_drain_addr = 32'h0;
  bit m_run = 1'b0, m_drain = 1'b0, m_err = 1'b0;

  mips_fetch_unit_if bus();
  mips_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic bit m_req();
    return m_run && !(m_err && !m_drain) && (m_drain || m_q.size() < DEPTH);
  endfunction

  function automatic logic [31:0] m_addr();
    return m_drain ? m_drain_addr : m_pc;
  endfunction

  // advance reference model on the inputs currently driven, then clock the DUT
  task automatic step();
    bit req, mis;
    req = m_req();
`ifdef FETCH_MISALIGN_TRAP_EN
    mis = bus.redirect_pc[1:0] != 2'b00;
`else
    mis = 1'b0;
`endif
    if (reset) begin
      m_q.delete(); m_pc = 0; m_drain_addr = 0; m_run = 0; m_drain = 0; m_err = 0;
    end else begin
      m_run = 1;
      if (bus.redirect_valid) begin
        m_q.delete();
        if (req && !bus.imem_ack) begin
          if (!m_drain) m_drain_addr = m_pc;
          m_drain = 1;
        end else m_drain = 0;
        m_pc = {bus.redirect_pc[31:2], 2'b00};
        m_err = mis;
      end else if (m_drain) begin
        if (bus.imem_ack) m_drain = 0;
      end else begin
        if (m_q.size() > 0 && bus.instr_ready) void'(m_q.pop_front());
        if (req && bus.imem_ack) begin
          m_q.push_back({m_pc, bus.imem_rdata});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
    bus.imem_rdata = rand_data ? $urandom : bus.imem_addr ^ K;
    bus.redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1; bus.imem_ack = 0; bus.instr_ready = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
    step(); step();
    reset = 0;
    step();
  endtask

  task automatic test_reset();
    reset = 1; bus.imem_ack = 1; bus.instr_ready = 1; bus.redirect_valid = 0; bus.redirect_pc = 0; bus.imem_rdata = 0;
    step(); step();
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.imem_addr); end
    checks++; if ({bus.instr_valid, bus.instr, bus.instr_pc} !== 65'h0) begin errors++; $display("FAIL reset_instr: got v=%b i=%h pc=%h want 0", bus.instr_valid, bus.instr, bus.instr_pc); end
    checks++; if (bus.misalign_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.misalign_err); end
    reset = 0;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL release_req: got %b want 0", bus.imem_req); end
    step();
    checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL first_req: got req=%b addr=%h want 1/0", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_stream();
    do_reset();
    bus.imem_ack = 1; bus.instr_ready = 1;
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL stream_idle: got %b want 0", bus.instr_valid); end
    step();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] pc;
      pc = 32'(i * 4);
      checks++; if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, pc, pc ^ K}) begin errors++; $display("FAIL stream_%0d: got v=%b pc=%h i=%h want pc=%h i=%h", i, bus.instr_valid, bus.instr_pc, bus.instr, pc, pc ^ K); end
      step();
    end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    bus.imem_ack = 1; bus.instr_ready = 0; n = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.imem_req) n++;
      step();
    end
    checks++; if (n !== DEPTH) begin errors++; $display("FAIL full_acks: got %0d want %0d", n, DEPTH); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL full_req: got %b want 0", bus.imem_req); end
    bus.imem_ack = 0; bus.instr_ready = 1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] pc;
      pc = 32'(i * 4);
      checks++; if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, pc, pc ^ K}) begin errors++; $display("FAIL drain_%0d: got v=%b pc=%h i=%h want pc=%h", i, bus.instr_valid, bus.instr_pc, bus.instr, pc); end
      step();
    end
    checks++; if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, 32'h10, 1'b0}) begin errors++; $display("FAIL resume: got req=%b addr=%h v=%b want 1/10/0", bus.imem_req, bus.imem_addr, bus.instr_valid); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    bus.instr_ready = 1; bus.imem_ack = 1; bus.redirect_valid = 1; bus.redirect_pc = 32'h20;
    step();
    checks++; if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, 32'h20, 1'b0}) begin errors++; $display("FAIL rw_setup: got req=%b addr=%h v=%b want 1/20/0", bus.imem_req, bus.imem_addr, bus.instr_valid); end
    bus.imem_ack = 0; bus.redirect_valid = 1; bus.redirect_pc = 32'h100;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++; if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, 32'h20, 1'b0}) begin errors++; $display("FAIL rw_hold_%0d: got req=%b addr=%h v=%b want 1/20/0", i, bus.imem_req, bus.imem_addr, bus.instr_valid); end
      if (i == 2) bus.imem_ack = 1;
      step();
    end
    checks++; if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, 32'h100, 1'b0}) begin errors++; $display("FAIL rw_target: got req=%b addr=%h v=%b want 1/100/0", bus.imem_req, bus.imem_addr, bus.instr_valid); end
    step();
    checks++; if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 32'h100, 32'h100 ^ K}) begin errors++; $display("FAIL rw_first: got v=%b pc=%h i=%h want pc=100", bus.instr_valid, bus.instr_pc, bus.instr); end
  endtask

  task automatic test_simul();
    do_reset();
    bus.imem_ack = 1; bus.instr_ready = 0;
    repeat (6) step();
    checks++; if ({bus.imem_req, bus.instr_valid} !== 2'b01) begin errors++; $display("FAIL sim_full: got req=%b v=%b want 0/1", bus.imem_req, bus.instr_valid); end
    bus.instr_ready = 1; bus.redirect_valid = 1; bus.redirect_pc = 32'h300;
    step();
    checks++; if ({bus.instr_valid, bus.imem_req, bus.imem_addr} !== {2'b01, 32'h300}) begin errors++; $display("FAIL sim_flush: got v=%b req=%b addr=%h want 0/1/300", bus.instr_valid, bus.imem_req, bus.imem_addr); end
    step();
    checks++; if ({bus.instr_valid, bus.instr_pc} !== {1'b1, 32'h300}) begin errors++; $display("FAIL sim_first: got v=%b pc=%h want 1/300", bus.instr_valid, bus.instr_pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.imem_ack = 1; bus.instr_ready = 1; bus.redirect_valid = 1; bus.redirect_pc = 32'hFFFF_FFF8;
    step();
    checks++; if ({bus.instr_valid, bus.imem_addr} !== {1'b0, 32'hFFFF_FFF8}) begin errors++; $display("FAIL wrap_req: got v=%b addr=%h want 0/fffffff8", bus.instr_valid, bus.imem_addr); end
    step();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] pc;
      pc = 32'hFFFF_FFF8 + 32'(i * 4);
      checks++; if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, pc, pc ^ K}) begin errors++; $display("FAIL wrap_%0d: got v=%b pc=%h want %h", i, bus.instr_valid, bus.instr_pc, pc); end
      step();
    end
  endtask

  task automatic test_misalign();
    do_reset();
    bus.imem_ack = 1; bus.instr_ready = 1; bus.redirect_valid = 1; bus.redirect_pc = 32'h102;
    step();
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      checks++; if ({bus.misalign_err, bus.imem_req, bus.instr_valid} !== 3'b100) begin errors++; $display("FAIL mis_halt_%0d: got err=%b req=%b v=%b want 1/0/0", i, bus.misalign_err, bus.imem_req, bus.instr_valid); end
      step();
    end
    bus.redirect_valid = 1; bus.redirect_pc = 32'h200;
    step();
    checks++; if ({bus.misalign_err, bus.imem_req, bus.imem_addr} !== {2'b01, 32'h200}) begin errors++; $display("FAIL mis_exit: got err=%b req=%b addr=%h want 0/1/200", bus.misalign_err, bus.imem_req, bus.imem_addr); end
    step();
    checks++; if ({bus.instr_valid, bus.instr_pc} !== {1'b1, 32'h200}) begin errors++; $display("FAIL mis_first: got v=%b pc=%h want 1/200", bus.instr_valid, bus.instr_pc); end
`else
    checks++; if ({bus.misalign_err, bus.imem_req, bus.imem_addr} !== {2'b01, 32'h100}) begin errors++; $display("FAIL mis_align: got err=%b req=%b addr=%h want 0/1/100", bus.misalign_err, bus.imem_req, bus.imem_addr); end
    step();
    checks++; if ({bus.instr_valid, bus.instr_pc} !== {1'b1, 32'h100}) begin errors++; $display("FAIL mis_first: got v=%b pc=%h want 1/100", bus.instr_valid, bus.instr_pc); end
`endif
  endtask

  task automatic test_random();
    rand_data = 1;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bit vv;
      logic [31:0] ep, ei, rp;
      vv = m_q.size() > 0;
      ep = vv ? m_q[0][63:32] : 32'h0;
      ei = vv ? m_q[0][31:0] : 32'h0;
      checks++; if ({bus.imem_req, bus.imem_addr} !== {m_req(), m_addr()}) begin errors++; $display("FAIL rand_req cyc=%0d: got req=%b addr=%h want req=%b addr=%h", i, bus.imem_req, bus.imem_addr, m_req(), m_addr()); end
      checks++; if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {vv, ep, ei}) begin errors++; $display("FAIL rand_instr cyc=%0d: got v=%b pc=%h i=%h want v=%b pc=%h i=%h", i, bus.instr_valid, bus.instr_pc, bus.instr, vv, ep, ei); end
      checks++; if (bus.misalign_err !== m_err) begin errors++; $display("FAIL rand_err cyc=%0d: got %b want %b", i, bus.misalign_err, m_err); end
      rp = $urandom;
      if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) rp[31:4] = 28'hFFF_FFFF;
      bus.imem_ack = $urandom_range(0, 2) != 0;
      bus.instr_ready = ((i / 200) % 2 == 0) ? $urandom_range(0, 3) != 0 : $urandom_range(0, 3) == 0;
      bus.redirect_valid = $urandom_range(0, 15) == 0;
      bus.redirect_pc = rp;
      reset = $urandom_range(0, 249) == 0;
      step();
    end
    reset = 0;
    rand_data = 0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_simul();
    test_wrap();
    test_misalign();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Instruction fetch stage for the non-pipelined MIPS core. It sits directly upstream of the CPU's `instruction` input. It issues word reads to instruction memory over a req/ack handshake and buffers returned words with their PCs in a small prefetch queue. It presents them to the core over a valid/ready interface. Jump/JR targets computed by the core come back as a redirect that flushes the queue and restarts fetch.

## Interface
- `DEPTH`, 4: prefetch queue entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; word aligned.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `imem_req`  out  1  read request; held until accepted.
- `imem_addr`  out  32  word address of request, bits[1:0]=0.
- `imem_ack`  in  1  request accepted and `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `redirect_valid`  in  1  one-cycle pulse: restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new fetch address.
- `instr_valid`  out  1  queue head valid.
- `instr`  out  32  queue head instruction.
- `instr_pc`  out  32  address of `instr`.
- `instr_ready`  in  1  core consumes head this cycle.
- `misalign_err`  out  1  sticky misaligned-redirect flag; tied 0 unless `FETCH_MISALIGN_TRAP_EN`.

## Operation
- State machine: FETCH, DRAIN, HALT. HALT exists only with the macro.
- FETCH: `imem_req`=1 when `count < DEPTH`.
  - `imem_addr`=`fetch_pc`.
  - A transfer occurs on `imem_req && imem_ack` in the same cycle; a zero-wait ack is legal.
  - On transfer: push {`fetch_pc`, `imem_rdata`} and set `fetch_pc += 4` (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- Request stability: once `imem_req` is asserted, `imem_addr` and `imem_req` hold until ack. This holds through redirects.
- Pop: on `instr_valid && instr_ready`, advance the read pointer.
- Simultaneous push and pop: `count` is unchanged.
- Full (`count==DEPTH`): `imem_req`=0.
- Pointers wrap modulo DEPTH.
- Redirect has priority over push/pop in its cycle. On redirect:
  - The queue is flushed (`count`←0) and any pop that cycle is ignored.
  - `fetch_pc`←{`redirect_pc[31:2]`, 2'b00}.
  - If `imem_req`=1 and `imem_ack`=0: go to DRAIN, keep the old `imem_addr`.
  - If acked that same cycle: discard the data and stay in FETCH.
- DRAIN: `imem_req`=1 at the old address.
  - On ack: discard data, go to FETCH with the new `fetch_pc`.
  - A further redirect in DRAIN only updates `fetch_pc`.
- `instr`/`instr_pc` read 0 whenever `instr_valid`=0.

## Timing
- Reset values, held in any cycle where `reset`=1: `imem_req`=0, `imem_addr`=RESET_PC, `instr_valid`=0, `instr`=0, `instr_pc`=0, `misalign_err`=0, state FETCH, `count`=0, `fetch_pc`=RESET_PC.
- First request: cycle after reset deasserts.
- Reset mid-request or mid-DRAIN abandons the request. Memory must tolerate `imem_req` dropping on reset.
- Latency: ack in cycle N → `instr_valid`=1 with that word in N+1.
- Throughput: zero-wait memory and `instr_ready`=1 give one instruction per cycle, with consecutive addresses on consecutive cycles.
- Redirect in cycle N:
  - `instr_valid`=0 in N+1.
  - If no DRAIN: new request at the target in N+1, first target instruction valid in N+2 at the earliest.
- `imem_req` and `imem_addr` are driven from registered state and `count` only; no combinational path from `imem_ack` or `instr_ready`.
- `instr_valid`, `instr` and `instr_pc` come from registers/queue storage only.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with `redirect_pc[1:0]`≠0 sets `misalign_err`=1, flushes the queue and enters HALT. An outstanding request is drained first, with data discarded.
  - In HALT, `imem_req`=0.
  - Only an aligned redirect leaves HALT, clearing `misalign_err` and fetching the target next cycle. Reset also clears it.
- `FETCH_MISALIGN_TRAP_EN` undefined:
  - `redirect_pc[1:0]` is silently cleared, `misalign_err` is constant 0 and no HALT state is built.

## Test plan
- Zero-wait streaming: reset, `imem_ack`=1, `instr_ready`=1, `imem_rdata`=addr^32'hA5A5_0000. Required: `instr_pc` 0,4,8,… one per cycle, `instr` matches, first valid 2 cycles after reset release.
- Backpressure/full: DEPTH=4, `instr_ready`=0. Required: exactly 4 acks, then `imem_req`=0. Raise ready: instructions at PC 0,4,8,12 in order, fetch resumes at 16.
- Redirect during wait: request at 0x20 outstanding, ack delayed 3 cycles, redirect to 0x100. Required: `imem_addr` holds 0x20 until ack, 0x20 data never appears, next request 0x100, first `instr_pc`=0x100.
- Simultaneous redirect+pop+ack: full queue, all three in one cycle. Required: `instr_valid`=0 next cycle, `imem_addr`=target.
- PC wrap: redirect to 32'hFFFF_FFF8, streaming. Required: `instr_pc` FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Misaligned redirect to 0x102. With macro: `misalign_err`=1, `imem_req`=0 until redirect to 0x200. Without macro: fetch at 0x100.
